// File: rtl/serial_mag_comparator_if.sv
// Handshake and result bundle for serial_mag_comparator.
//   start      requester -> comparator, sampled only while idle
//   a, b       WIDTH-bit operands, latched with an accepted start
//   busy       comparator is in RUN or DONE
//   done       one-cycle pulse, results valid
//   cmp_code   final code: 01 A==B, 1x A>B, 00 A<B
//   gt/eq/lt   decoded one-hot result, held until the next accepted start
interface serial_mag_comparator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [1:0]       cmp_code;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, cmp_code, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, cmp_code, gt, eq, lt
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: latches two operands on start, then walks
// them MSB->LSB one bit per clock, carrying a 2-bit running compare code.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_mag_comparator_if slave: start/a/b in, busy/done/results out
module serial_mag_comparator #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_mag_comparator_if.slave        bus
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0]  CODE_EQ = 2'b01;
  localparam logic [1:0]  CODE_LT = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       code_q, code_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [1:0]       cmp_code_q, cmp_code_d;

  logic [WIDTH-1:0] a_sh_c, b_sh_c;
  logic             x_c, y_c;
  logic [1:0]       code_nxt_c;
  logic             finish_c;

  // Current bit pair; shifting avoids a zero-width index when WIDTH=1
  assign a_sh_c = a_q >> idx_q;
  assign b_sh_c = b_q >> idx_q;
  assign x_c    = a_sh_c[0];
  assign y_c    = b_sh_c[0];

  // One-bit comparator recurrence; codes 1x and 00 are absorbing
  assign code_nxt_c[0] = ~code_q[1] & code_q[0] & (x_c ~^ y_c);
  assign code_nxt_c[1] = code_q[1] | (~code_q[1] & code_q[0] & x_c & ~y_c);

  assign finish_c = (idx_q == '0) || ((EARLY_EXIT != 0) && (code_nxt_c != CODE_EQ));

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    code_d     = code_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gt_d       = gt_q;
    eq_d       = eq_q;
    lt_d       = lt_q;
    cmp_code_d = cmp_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          code_d  = CODE_EQ;
          idx_d   = IDX_W'(WIDTH - 1);
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        code_d = code_nxt_c;
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end
        if (finish_c) begin
          gt_d       = code_nxt_c[1];
          eq_d       = (code_nxt_c == CODE_EQ);
          lt_d       = (code_nxt_c == CODE_LT);
          cmp_code_d = code_nxt_c;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      code_q     <= CODE_EQ;
      idx_q      <= IDX_W'(WIDTH - 1);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      cmp_code_q <= CODE_EQ;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
      cmp_code_q <= cmp_code_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.gt       = gt_q;
  assign bus.eq       = eq_q;
  assign bus.lt       = lt_q;
  assign bus.cmp_code = cmp_code_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed and random checks of serial_mag_comparator: three instances
// (WIDTH=8 early exit, WIDTH=8 full scan, WIDTH=1) driven in lockstep.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;

  always #5 clk = ~clk;

  serial_mag_comparator_if #(.WIDTH(8)) if_e1 ();
  serial_mag_comparator_if #(.WIDTH(8)) if_e0 ();
  serial_mag_comparator_if #(.WIDTH(1)) if_w1 ();

  assign if_e1.start = start;
  assign if_e1.a     = a;
  assign if_e1.b     = b;
  assign if_e0.start = start;
  assign if_e0.a     = a;
  assign if_e0.b     = b;
  assign if_w1.start = start;
  assign if_w1.a     = a[0];
  assign if_w1.b     = b[0];

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) dut_e1 (.clk(clk), .rst_n(rst_n), .bus(if_e1));
  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) dut_e0 (.clk(clk), .rst_n(rst_n), .bus(if_e0));
  serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(if_w1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // 1-based position from MSB of the first differing bit, 8 when equal
  function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
    for (int i = 7; i >= 0; i--) begin
      if (x[i] != y[i]) return 8 - i;
    end
    return 8;
  endfunction

  function automatic logic [2:0] gel(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? 3'b100 : (x == y) ? 3'b010 : 3'b001;
  endfunction

  function automatic logic [1:0] code_of(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? 2'b10 : (x == y) ? 2'b01 : 2'b00;
  endfunction

  // One transaction on all three instances; latency counted in edges after accept
  task automatic run_txn(input logic [7:0] av, input logic [7:0] bv, input string tag);
    int lat_e1 = 0, lat_e0 = 0, lat_w1 = 0;
    int cnt_e1 = 0, cnt_e0 = 0, cnt_w1 = 0;
    logic [7:0] a0, b0;
    a0 = {7'd0, av[0]};
    b0 = {7'd0, bv[0]};
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      if (if_e1.done) begin cnt_e1++; if (lat_e1 == 0) lat_e1 = c; end
      if (if_e0.done) begin cnt_e0++; if (lat_e0 == 0) lat_e0 = c; end
      if (if_w1.done) begin cnt_w1++; if (lat_w1 == 0) lat_w1 = c; end
    end
    check({tag, " e1 latency"}, lat_e1, first_diff(av, bv));
    check({tag, " e1 done pulses"}, cnt_e1, 1);
    check({tag, " e1 gt/eq/lt"}, {if_e1.gt, if_e1.eq, if_e1.lt}, gel(av, bv));
    check({tag, " e1 cmp_code"}, if_e1.cmp_code, code_of(av, bv));
    check({tag, " e0 latency"}, lat_e0, 8);
    check({tag, " e0 done pulses"}, cnt_e0, 1);
    check({tag, " e0 gt/eq/lt"}, {if_e0.gt, if_e0.eq, if_e0.lt}, gel(av, bv));
    check({tag, " e0 cmp_code"}, if_e0.cmp_code, code_of(av, bv));
    check({tag, " w1 latency"}, lat_w1, 1);
    check({tag, " w1 done pulses"}, cnt_w1, 1);
    check({tag, " w1 gt/eq/lt"}, {if_w1.gt, if_w1.eq, if_w1.lt}, gel(a0, b0));
    check({tag, " w1 cmp_code"}, if_w1.cmp_code, code_of(a0, b0));
  endtask

  initial begin
    int d_e0, d_e1, any_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("reset e1 busy/done", {if_e1.busy, if_e1.done}, 2'b00);
    check("reset e1 gt/eq/lt", {if_e1.gt, if_e1.eq, if_e1.lt}, 3'b000);
    check("reset e1 cmp_code", if_e1.cmp_code, 2'b01);
    check("reset e0 cmp_code", if_e0.cmp_code, 2'b01);
    @(negedge clk) rst_n = 1'b1;

    run_txn(8'h5A, 8'h5A, "equal");
    run_txn(8'h80, 8'h7F, "msb_gt");
    run_txn(8'h12, 8'h13, "lsb_lt");
    run_txn(8'h00, 8'hFF, "zero_ff");

    // start held high with operands toggling while busy
    d_e0 = 0; d_e1 = 0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      #1;
      a = c[0] ? 8'hFF : 8'hF0;
      b = c[0] ? 8'h00 : 8'h0F;
      @(posedge clk);
      #1;
      if (c <= 9 && if_e0.done) d_e0++;
      if (c <= 4 && if_e1.done) d_e1++;
      if (c == 3) begin
        check("hold e1 done at 3", if_e1.done, 1'b1);
        check("hold e1 gt/eq/lt", {if_e1.gt, if_e1.eq, if_e1.lt}, 3'b001);
      end
      if (c == 8) begin
        check("hold e0 done at 8", if_e0.done, 1'b1);
        check("hold e0 gt/eq/lt", {if_e0.gt, if_e0.eq, if_e0.lt}, 3'b001);
        check("hold e0 cmp_code", if_e0.cmp_code, 2'b00);
      end
      if (c == 9)  check("hold e0 idle busy", if_e0.busy, 1'b0);
      if (c == 10) check("hold e0 reaccept busy", if_e0.busy, 1'b1);
    end
    check("hold e0 done pulses", d_e0, 1);
    check("hold e1 done pulses", d_e1, 1);
    start = 1'b0;
    repeat (12) @(posedge clk);

    // reset in the middle of RUN
    @(negedge clk);
    a = 8'h12; b = 8'h13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst e1 busy/done", {if_e1.busy, if_e1.done}, 2'b00);
    check("midrst e0 busy/done", {if_e0.busy, if_e0.done}, 2'b00);
    check("midrst e0 gt/eq/lt", {if_e0.gt, if_e0.eq, if_e0.lt}, 3'b000);
    check("midrst e1 cmp_code", if_e1.cmp_code, 2'b01);
    @(negedge clk) rst_n = 1'b1;
    any_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (if_e1.done || if_e0.done || if_w1.done) any_done++;
    end
    check("midrst no done", any_done, 0);
    run_txn(8'h00, 8'hFF, "post_rst");

    for (int n = 0; n < 1000; n++) begin
      run_txn(8'($urandom), 8'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
